spi_shift_engine: RTL and testbench
===================================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL: parameter DATA_W, default 32, frame length in bits (range 8..32).
REQ-002 SHALL: clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL: rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL: ClockDiv  input  8  SCLK half-period select, in clk cycles minus one.
REQ-005 SHALL: Start  input  1  single-cycle transfer request.
REQ-006 SHALL: DataIn  input  DATA_W  transmit word, sampled on an accepted Start.
REQ-007 SHALL: Busy  output  1  high while a transfer is in progress.
REQ-008 SHALL: DataOut  output  DATA_W  last fully received word.
REQ-009 SHALL: sclk  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL: mosi  output  1  serial data out.
REQ-011 SHALL: miso  input  1  serial data in.
REQ-012 SHALL: csn  output  1  active-low chip select.

Function
REQ-013 SHALL: states IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on Start, SETUP->SHIFT, SHIFT->HOLD after the last bit, HOLD->IDLE.
REQ-014 SHALL: Start accepted only in IDLE; Start while Busy=1 ignored, no state or data change.
REQ-015 SHALL: on accept, latch ClockDiv and DataIn; later input changes do not affect the current transfer.
REQ-016 SHALL: half-period H = latched ClockDiv + 1 clk cycles; ClockDiv=0 gives H=1.
REQ-017 SHALL: Busy and csn=0 from the cycle after accept for exactly (2*DATA_W+2)*H cycles: SETUP H, SHIFT 2*DATA_W*H, HOLD H.
REQ-018 SHALL: mosi presents the first bit from SETUP entry; it changes only on sclk falling edges.
REQ-019 SHALL: miso sampled on each sclk rising edge; DATA_W rising edges per transfer.
REQ-020 SHALL: sclk low throughout SETUP, HOLD and IDLE; SHIFT ends with sclk low.
REQ-021 SHALL: DataOut updated once, in the cycle Busy falls; held until the next completed transfer.
REQ-022 SHALL: after Busy falls, next Start accepted in the immediately following cycle.
REQ-023 SHALL: mosi=0 in IDLE.

Reset
REQ-024 SHALL: rstn low at any time, including mid-transfer, forces IDLE, Busy=0, csn=1, sclk=0, mosi=0, DataOut=0, aborting without a DataOut update.

Configuration
REQ-025 SHALL: macro SPI_LSB_FIRST_EN defined -> transmit and receive LSB first (DataIn[0] first, first received bit lands in DataOut[0]).
REQ-026 SHALL: macro absent -> MSB first (DataIn[DATA_W-1] first, first received bit lands in DataOut[DATA_W-1]).

Structure
REQ-027 SHALL: shared package spi_pkg holds the state enumeration and the default DATA_W constant.
REQ-028 SHALL: sub-module spi_clk_div generates the half-period tick from the latched divider, restarted on each accepted Start.

Verification
REQ-029 SHALL: mosi looped to miso, ClockDiv=0, DataIn=0xA5C30F96, Start -> Busy high 66 cycles, sclk period 2 clk, DataOut=0xA5C30F96.
REQ-030 SHALL: ClockDiv=3, DataIn=0x0000FFFF, miso=1 -> sclk period 8 clk, Busy 264 cycles, DataOut=0xFFFFFFFF.
REQ-031 SHALL: Start pulsed again 10 cycles into a transfer, with DataIn changed to 0x12345678 -> ignored, original frame completes unchanged, single Busy window.
REQ-032 SHALL: ClockDiv changed from 1 to 7 mid-transfer -> sclk period stays 4 clk until Busy falls.
REQ-033 SHALL: rstn low at bit 12 -> next cycle csn=1, sclk=0, Busy=0, DataOut=0; a new Start then completes normally.
REQ-034 SHALL: SPI_LSB_FIRST_EN defined, DataIn=0x00000001, loopback -> mosi=1 on the first bit only, DataOut=0x00000001.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encoding,
// default frame width and the clock-divider field width.
package spi_pkg;

    // Default frame length in bits (legal range 8..32)
    localparam int SPI_DATA_W_DEF = 32;

    // Width of the SCLK half-period select field
    localparam int SPI_DIV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI shift engine.
// Emits a one-cycle tick every (div_i + 1) clk cycles; restart_i forces the
// count back to zero so the first half-period after an accepted Start is full.
module spi_clk_div
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 restart_i,
    input  logic [SPI_DIV_W-1:0] div_i,
    output logic                 tick_o
);

    logic [SPI_DIV_W-1:0] cnt_q;
    logic [SPI_DIV_W-1:0] cnt_d;

    assign tick_o = (cnt_q == div_i);

    // Next count: wrap on tick or on restart, otherwise increment
    always_comb begin
        cnt_d = cnt_q + SPI_DIV_W'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine.
// Frame: SETUP (one half-period, sclk low, first bit on mosi), SHIFT (2*DATA_W
// half-periods, starting with the first rising edge, ending low), HOLD (one
// half-period, sclk low). DataOut is written at the HOLD->IDLE step.
// Build option: define SPI_LSB_FIRST_EN for LSB-first transmit and receive;
// by default frames are MSB first.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF
)
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SPI_DIV_W-1:0] ClockDiv,
    input  logic                 Start,
    input  logic [DATA_W-1:0]    DataIn,
    output logic                 Busy,
    output logic [DATA_W-1:0]    DataOut,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 csn
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_e           state_q, state_d;
    logic [SPI_DIV_W-1:0] div_q, div_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic [DATA_W-1:0]    rx_q, rx_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 sclk_q, sclk_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

    logic                 tick;
    logic                 accept;
    logic                 all_bits_done;
    logic                 tx_bit;
    logic [DATA_W-1:0]    tx_shifted;
    logic [DATA_W-1:0]    rx_shifted;

    // A Start only counts in IDLE; while busy it is simply ignored
    assign accept        = (state_q == ST_IDLE) && Start;
    // bit_cnt counts falling edges; once all have occurred no further rise
    assign all_bits_done = (bit_cnt_q == CNT_W'(DATA_W));

`ifdef SPI_LSB_FIRST_EN
    assign tx_bit     = tx_q[0];
    assign tx_shifted = {1'b0, tx_q[DATA_W-1:1]};
    assign rx_shifted = {miso, rx_q[DATA_W-1:1]};
`else
    assign tx_bit     = tx_q[DATA_W-1];
    assign tx_shifted = {tx_q[DATA_W-2:0], 1'b0};
    assign rx_shifted = {rx_q[DATA_W-2:0], miso};
`endif

    // Half-period timing, re-aligned on every accepted Start
    spi_clk_div u_clk_div (
        .clk       (clk),
        .rstn      (rstn),
        .restart_i (accept),
        .div_i     (div_q),
        .tick_o    (tick)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_SETUP;
            ST_SETUP: if (tick)  state_d = ST_SHIFT;
            ST_SHIFT: if (tick && !sclk_q && all_bits_done) state_d = ST_HOLD;
            ST_HOLD:  if (tick)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: chip select and busy span every non-idle state
    always_comb begin
        Busy = 1'b1;
        csn  = 1'b0;
        if (state_q == ST_IDLE) begin
            Busy = 1'b0;
            csn  = 1'b1;
        end
    end

    // Datapath next state: latch on accept, rise/sample and fall/shift on ticks
    always_comb begin
        div_d     = div_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        sclk_d    = sclk_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    div_d     = ClockDiv;
                    tx_d      = DataIn;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                end
            end
            ST_SETUP: begin
                // First rising edge coincides with entry into SHIFT
                if (tick) begin
                    sclk_d = 1'b1;
                    rx_d   = rx_shifted;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        tx_d      = tx_shifted;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (!all_bits_done) begin
                        sclk_d = 1'b1;
                        rx_d   = rx_shifted;
                    end
                end
            end
            ST_HOLD: begin
                // Publish the word and return mosi to 0 for IDLE
                if (tick) begin
                    dout_d = rx_q;
                    tx_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_q     <= div_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            sclk_q    <= sclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_bit;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (DATA_W = 32).
// Outputs are sampled on the falling clk edge; inputs change there too.
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  ClockDiv;
    logic        Start;
    logic [31:0] DataIn;
    logic        Busy;
    logic [31:0] DataOut;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        csn;

    logic        loop_en;
    logic        miso_drv;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ClockDiv (ClockDiv),
        .Start    (Start),
        .DataIn   (DataIn),
        .Busy     (Busy),
        .DataOut  (DataOut),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .csn      (csn)
    );

`ifdef SPI_LSB_FIRST_EN
    localparam int FIRST_ONE_EXP = 1;
`else
    localparam int FIRST_ONE_EXP = 32;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    // Per-transfer measurements
    int busy_cyc;
    int rises;
    int period_bad;
    int csn_bad;
    int mosi_bad;
    int ones;
    int first_one;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Issue one Start and watch the whole Busy window
    task automatic run_xfer(input logic [7:0] div, input logic [31:0] data, input int exp_period,
                            input int poke_cyc, input logic [31:0] poke_data,
                            input int div_cyc, input logic [7:0] new_div);
        int   last_rise;
        logic sclk_p, mosi_p, busy_p;
        ClockDiv = div;
        DataIn   = data;
        Start    = 1'b1;
        @(negedge clk);
        Start      = 1'b0;
        busy_cyc   = 0;
        rises      = 0;
        period_bad = 0;
        csn_bad    = 0;
        mosi_bad   = 0;
        ones       = 0;
        first_one  = 0;
        last_rise  = -1;
        sclk_p     = sclk;
        mosi_p     = mosi;
        busy_p     = 1'b0;
        while (Busy && busy_cyc < 3000) begin
            busy_cyc++;
            if (csn !== 1'b0) csn_bad++;
            if (sclk && !sclk_p) begin
                rises++;
                if (last_rise >= 0 && (busy_cyc - last_rise) != exp_period) period_bad++;
                last_rise = busy_cyc;
                if (mosi) begin
                    ones++;
                    if (first_one == 0) first_one = rises;
                end
            end
            if (busy_p && (mosi !== mosi_p) && !(sclk_p && !sclk)) mosi_bad++;
            if (busy_cyc == poke_cyc) begin
                Start  = 1'b1;
                DataIn = poke_data;
            end
            if (busy_cyc == poke_cyc + 1) Start = 1'b0;
            if (busy_cyc == div_cyc) ClockDiv = new_div;
            sclk_p = sclk;
            mosi_p = mosi;
            busy_p = 1'b1;
            @(negedge clk);
        end
        Start = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input int exp_busy, input logic [31:0] exp_dout);
        check_value({tag, "_busy_cycles"}, busy_cyc, exp_busy);
        check_value({tag, "_sclk_rises"},  rises, 32);
        check_value({tag, "_period_bad"},  period_bad, 0);
        check_value({tag, "_csn_bad"},     csn_bad, 0);
        check_value({tag, "_mosi_bad"},    mosi_bad, 0);
        check_value({tag, "_dataout"},     DataOut, exp_dout);
        check_value({tag, "_end_busy"},    32'(Busy), 0);
        check_value({tag, "_end_csn"},     32'(csn), 1);
        check_value({tag, "_end_sclk"},    32'(sclk), 0);
        check_value({tag, "_end_mosi"},    32'(mosi), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rstn     = 1'b0;
        Start    = 1'b0;
        ClockDiv = 8'd0;
        DataIn   = 32'd0;
        loop_en  = 1'b1;
        miso_drv = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_busy",    32'(Busy), 0);
        check_value("rst_csn",     32'(csn), 1);
        check_value("rst_sclk",    32'(sclk), 0);
        check_value("rst_mosi",    32'(mosi), 0);
        check_value("rst_dataout", DataOut, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback, fastest clock
        run_xfer(8'd0, 32'hA5C30F96, 2, -1, 32'd0, -1, 8'd0);
        check_xfer("loop_div0", 66, 32'hA5C30F96);

        // Back-to-back Start; miso held high, divider 3
        loop_en  = 1'b0;
        miso_drv = 1'b1;
        run_xfer(8'd3, 32'h0000FFFF, 8, -1, 32'd0, -1, 8'd0);
        check_xfer("miso1_div3", 264, 32'hFFFFFFFF);

        // miso held low
        miso_drv = 1'b0;
        run_xfer(8'd0, 32'hFFFFFFFF, 2, -1, 32'd0, -1, 8'd0);
        check_xfer("miso0_div0", 66, 32'h00000000);

        // Start re-pulsed mid-transfer with new data: must be ignored
        loop_en = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(8'd0, 32'h3C5A9617, 2, 10, 32'h12345678, -1, 8'd0);
        check_xfer("restart_ignored", 66, 32'h3C5A9617);
        repeat (3) @(negedge clk);
        check_value("restart_single_window", 32'(Busy), 0);

        // ClockDiv changed mid-transfer: latched value governs
        run_xfer(8'd1, 32'h0F0F1234, 4, -1, 32'd0, 5, 8'd7);
        check_xfer("div_change", 132, 32'h0F0F1234);

        // Reset at bit 12 aborts without a DataOut update
        ClockDiv = 8'd1;
        DataIn   = 32'hCAFEF00D;
        Start    = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        rises = 0;
        cyc   = 0;
        begin
            logic sp;
            sp = sclk;
            while (rises < 12 && cyc < 500) begin
                @(negedge clk);
                cyc++;
                if (sclk && !sp) rises++;
                sp = sclk;
            end
        end
        check_value("abort_reached_bit12", rises, 12);
        rstn = 1'b0;
        @(negedge clk);
        check_value("abort_csn",     32'(csn), 1);
        check_value("abort_sclk",    32'(sclk), 0);
        check_value("abort_busy",    32'(Busy), 0);
        check_value("abort_mosi",    32'(mosi), 0);
        check_value("abort_dataout", DataOut, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(8'd2, 32'hDEADBEEF, 6, -1, 32'd0, -1, 8'd0);
        check_xfer("post_abort", 198, 32'hDEADBEEF);

        // Bit order: a single set bit appears once on mosi
        run_xfer(8'd0, 32'h00000001, 2, -1, 32'd0, -1, 8'd0);
        check_xfer("bit_order", 66, 32'h00000001);
        check_value("bit_order_ones",      ones, 1);
        check_value("bit_order_first_one", first_one, FIRST_ONE_EXP);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
